// File: rtl/control_div_pkg.sv
// rtl/control_div_pkg.sv - shared divider constants, state encoding and strobe decode
package control_div_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_SHIFT = 3'd2,
        S_CHECK = 3'd3,
        S_LOAD  = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } div_state_t;

    typedef struct packed {
        logic init;
        logic sh;
        logic lda;
        logic q_set;
        logic busy;
        logic done;
        logic err;
    } div_out_t;

    // Counter must hold the value WIDTH itself, hence one bit beyond $clog2.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    function automatic div_out_t decode_outputs(input div_state_t s);
        div_out_t o;
        o = '0;
        case (s)
            S_INIT: begin
                o.init = 1'b1;
                o.busy = 1'b1;
            end
            S_SHIFT: begin
                o.sh   = 1'b1;
                o.busy = 1'b1;
            end
            S_CHECK: o.busy = 1'b1;
            S_LOAD: begin
                o.lda   = 1'b1;
                o.q_set = 1'b1;
                o.busy  = 1'b1;
            end
            S_DONE:  o.done = 1'b1;
            S_ERROR: begin
                o.done = 1'b1;
                o.err  = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/count_div.sv
// rtl/count_div.sv - iteration down-counter with load, guarded decrement and zero flag
module count_div
    import control_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CW    = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          zero
);

    // Decrement is suppressed at zero so the count never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(WIDTH);
        end else if (dec && !zero) begin
            count <= count - CW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/control_div.sv
// rtl/control_div.sv - restoring-divider control FSM with registered Moore strobes
module control_div
    import control_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic START,
    input  logic MSB,
    input  logic DR_ZERO,
    output logic INIT,
    output logic SH,
    output logic LDA,
    output logic Q_SET,
    output logic BUSY,
    output logic DONE,
    output logic ERR
);

    localparam int CW = cnt_width(WIDTH);

    div_state_t    state;
    div_out_t      outs;
    logic [CW-1:0] count;
    logic          cnt_zero;
    logic          cnt_load;
    logic          cnt_dec;
    logic          last_iter;

    assign cnt_load  = (state == S_INIT);
    assign cnt_dec   = (state == S_CHECK);
    // In CHECK the count is still pre-decrement, so the last pass shows 1.
    assign last_iter = (count <= CW'(1));

    count_div #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_count (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .count (count),
        .zero  (cnt_zero)
    );

    // Strobes are registered together with the state, so they are a pure
    // decode of the state register and settle well before the falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            outs  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state <= S_INIT;
                        outs  <= decode_outputs(S_INIT);
                    end
                end
                S_INIT: begin
                    if (DR_ZERO) begin
                        state <= S_ERROR;
                        outs  <= decode_outputs(S_ERROR);
                    end else begin
                        state <= S_SHIFT;
                        outs  <= decode_outputs(S_SHIFT);
                    end
                end
                S_SHIFT: begin
                    state <= S_CHECK;
                    outs  <= decode_outputs(S_CHECK);
                end
                S_CHECK: begin
                    if (!MSB) begin
                        state <= S_LOAD;
                        outs  <= decode_outputs(S_LOAD);
                    end else if (last_iter) begin
                        state <= S_DONE;
                        outs  <= decode_outputs(S_DONE);
                    end else begin
                        state <= S_SHIFT;
                        outs  <= decode_outputs(S_SHIFT);
                    end
                end
                S_LOAD: begin
                    if (cnt_zero) begin
                        state <= S_DONE;
                        outs  <= decode_outputs(S_DONE);
                    end else begin
                        state <= S_SHIFT;
                        outs  <= decode_outputs(S_SHIFT);
                    end
                end
                S_DONE, S_ERROR: begin
                    if (!START) begin
                        state <= S_IDLE;
                        outs  <= decode_outputs(S_IDLE);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    outs  <= decode_outputs(S_IDLE);
                end
            endcase
        end
    end

    assign INIT  = outs.init;
    assign SH    = outs.sh;
    assign LDA   = outs.lda;
    assign Q_SET = outs.q_set;
    assign BUSY  = outs.busy;
    assign DONE  = outs.done;
    assign ERR   = outs.err;

endmodule

// File: tb/tb_control_div.sv
// tb/tb_control_div.sv - self-checking bench for control_div with a closed-loop datapath model
module tb_control_div;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst, start, msb, dr_zero;
    logic init, sh, lda, q_set, busy, done, err;

    int checks = 0;
    int errors = 0;
    int n_init, n_sh, n_lda, n_qset;
    int msb_mode;
    bit mon_on = 1'b0;

    logic [16:0] acc;
    logic [15:0] dv;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic [17:0] trial;

    always #5 clk = ~clk;

    control_div #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .START   (start),
        .MSB     (msb),
        .DR_ZERO (dr_zero),
        .INIT    (init),
        .SH      (sh),
        .LDA     (lda),
        .Q_SET   (q_set),
        .BUSY    (busy),
        .DONE    (done),
        .ERR     (err)
    );

    assign trial   = {1'b0, acc} - {2'b00, divisor};
    assign dr_zero = (divisor == 16'd0);

    always_comb begin
        msb = 1'b0;
        case (msb_mode)
            0:       msb = 1'b1;
            1:       msb = 1'b0;
            default: msb = trial[17];
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_latency(input int ones);
        return 1 + 2 * W + ones;
    endfunction

    // Reference restoring datapath, clocked on the falling edge.
    always @(negedge clk) begin
        if (init) begin
            acc <= '0;
            dv  <= dividend;
        end else if (sh) begin
            {acc, dv} <= {acc[15:0], dv, 1'b0};
        end else if (lda) begin
            acc <= trial[16:0];
        end
        if (q_set) dv[0] <= 1'b1;
    end

    always @(negedge clk) begin
        if (init)  n_init++;
        if (sh)    n_sh++;
        if (lda)   n_lda++;
        if (q_set) n_qset++;
        if (mon_on)
            check("strobe_mutex", 32'(int'(init) + int'(sh) + int'(lda) <= 1), 32'd1);
    end

    task automatic run_div(input bit hold, input int extra_at, output int lat);
        bit found;
        found = 1'b0;
        lat = -1;
        @(negedge clk); start = 1'b0;
        @(posedge clk);
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        n_init = 0; n_sh = 0; n_lda = 0; n_qset = 0;
        for (int i = 1; i <= 80 && !found; i++) begin
            @(negedge clk);
            start = hold || (i == extra_at);
            @(posedge clk); #1;
            if (done) begin
                found = 1'b1;
                lat = i;
            end
        end
    endtask

    initial begin
        int lat;
        int seen;
        int q, r, ones;

        rst = 1'b1; start = 1'b1; msb_mode = 0; divisor = 16'd1; dividend = 16'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            mon_on = 1'b1;
            check("rst_busy", busy, 0);
            check("rst_outs", {init, sh, lda, q_set, done, err}, 0);
        end
        @(negedge clk); rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("idle_outs", {init, sh, lda, q_set, busy, done, err}, 0);

        // MSB forced negative: no quotient bits
        msb_mode = 0;
        run_div(1'b0, 0, lat);
        check("m1_latency", lat, exp_latency(0));
        check("m1_init", n_init, 1);
        check("m1_sh", n_sh, W);
        check("m1_lda", n_lda, 0);
        check("m1_err", err, 0);
        @(posedge clk); #1;
        check("m1_back_idle", {busy, done}, 0);

        // MSB forced positive, stray START at cycle 10
        msb_mode = 1;
        run_div(1'b0, 10, lat);
        check("m0_latency", lat, exp_latency(W));
        check("m0_init", n_init, 1);
        check("m0_sh", n_sh, W);
        check("m0_lda", n_lda, W);
        check("m0_qset", n_qset, W);

        // Divide by zero
        divisor = 16'd0;
        run_div(1'b1, 0, lat);
        check("dz_latency", lat, 1);
        check("dz_err", err, 1);
        check("dz_busy", busy, 0);
        check("dz_init", n_init, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("dz_hold", {done, err}, 2'b11);
        end
        check("dz_sh", n_sh, 0);
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        check("dz_idle", {busy, done, err}, 0);

        // Reset after the 5th SH
        divisor = 16'd1; msb_mode = 1;
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        n_init = 0; n_sh = 0; n_lda = 0; n_qset = 0;
        @(negedge clk); start = 1'b0;
        seen = 0;
        for (int i = 0; i < 40 && seen < 5; i++) begin
            @(posedge clk); #1;
            if (sh) seen++;
        end
        check("mid_seen5", seen, 5);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_outs", {init, sh, lda, q_set, busy, done, err}, 0);
        @(negedge clk); rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("mid_sh", n_sh, 5);
        check("mid_lda", n_lda, 4);
        check("mid_idle", busy, 0);
        run_div(1'b0, 0, lat);
        check("mid_restart_sh", n_sh, W);
        check("mid_restart_lat", lat, exp_latency(W));

        // Closed loop 100 / 7
        msb_mode = 2; dividend = 16'd100; divisor = 16'd7;
        q = int'(dividend) / int'(divisor);
        r = int'(dividend) % int'(divisor);
        ones = $countones(q);
        run_div(1'b0, 0, lat);
        check("cl_quot", dv, q);
        check("cl_rem", acc, r);
        check("cl_sh", n_sh, W);
        check("cl_lda", n_lda, ones);
        check("cl_latency", lat, exp_latency(ones));

        // Random closed-loop divisions; odd ones hold START through DONE
        for (int k = 0; k < 12; k++) begin
            dividend = 16'($urandom_range(0, 65535));
            divisor  = (k % 3 == 0) ? 16'($urandom_range(1, 65535)) : 16'($urandom_range(1, 300));
            q = int'(dividend) / int'(divisor);
            r = int'(dividend) % int'(divisor);
            ones = $countones(q);
            run_div(k[0], 0, lat);
            check("rnd_quot", dv, q);
            check("rnd_rem", acc, r);
            check("rnd_lda", n_lda, ones);
            check("rnd_sh", n_sh, W);
            check("rnd_latency", lat, exp_latency(ones));
            if (k[0]) begin
                repeat (3) @(posedge clk);
                #1;
                check("hold_done", {busy, done}, 2'b01);
                check("hold_no_restart", n_init, 1);
                @(negedge clk); start = 1'b0;
                @(posedge clk); #1;
                check("hold_release", {busy, done}, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
